// File: rtl/decos_suma_pkg.sv
// Shared types and width helpers for the DecosSuma frame sequencer.
package decos_suma_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    REDUCE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  function automatic int frame_bits(input int samples, input int osf);
    return samples * osf;
  endfunction

  function automatic int frame_beats(input int frame, input int in_w);
    return frame / in_w;
  endfunction

  function automatic int frame_chunks(input int frame, input int chunk);
    return frame / chunk;
  endfunction

  function automatic int sum_w(input int frame);
    return $clog2(frame) + 1;
  endfunction

  // Counter width that stays legal when a count degenerates to one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/suma_chunk_popcnt.sv
// Combinational popcount of one CHUNK-bit slice of the frame.
module suma_chunk_popcnt #(
  parameter int CHUNK = 64
) (
  input  logic [CHUNK-1:0]       bits,
  output logic [$clog2(CHUNK):0] count
);

  localparam int CW = $clog2(CHUNK) + 1;

  // Ripple sum of the slice bits.
  always_comb begin
    count = {CW{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      count = count + {{(CW-1){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/decos_suma_seq.sv
// Frame sequencer: collects a frame in beats, counts its ones chunk by chunk, returns the total.
// Optional threshold compare (Threshold/Hit ports) is built when DECOS_THRESH_EN is defined.
module decos_suma_seq
  import decos_suma_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int IN_W    = 8,
  parameter int CHUNK   = 64
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Clear,
  input  logic [IN_W-1:0]               In_Data,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  output logic [SAMPLES*OSF-1:0]        Frame_Out,
  output logic [$clog2(SAMPLES*OSF):0]  Out_Sum,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic [CNT_W-1:0]              Frame_Cnt
`ifdef DECOS_THRESH_EN
  ,
  input  logic [$clog2(SAMPLES*OSF):0]  Threshold,
  output logic                          Hit
`endif
);

  localparam int FRAME  = frame_bits(SAMPLES, OSF);
  localparam int BEATS  = frame_beats(FRAME, IN_W);
  localparam int CHUNKS = frame_chunks(FRAME, CHUNK);
  localparam int SUM_W  = sum_w(FRAME);
  localparam int BW     = idx_w(BEATS);
  localparam int KW     = idx_w(CHUNKS);
  localparam int PCW    = $clog2(CHUNK) + 1;

  if ((FRAME % IN_W) != 0) begin : g_bad_in_w
    $error("decos_suma_seq: frame width is not a multiple of IN_W");
  end
  if ((FRAME % CHUNK) != 0) begin : g_bad_chunk
    $error("decos_suma_seq: frame width is not a multiple of CHUNK");
  end

  state_t           state;
  logic [BW-1:0]    beat_cnt;
  logic [KW-1:0]    chunk_cnt;
  logic [SUM_W-1:0] acc;
  logic [PCW-1:0]   chunk_ones;
  logic [SUM_W-1:0] chunk_total;

  suma_chunk_popcnt #(.CHUNK(CHUNK)) u_popcnt (
    .bits  (Frame_Out[int'(chunk_cnt)*CHUNK +: CHUNK]),
    .count (chunk_ones)
  );

  assign chunk_total = acc + SUM_W'(chunk_ones);
  assign In_Ready    = (state == FILL);

  // Sequencer: frame capture, chunked reduction and result hand-off.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= FILL;
      beat_cnt  <= {BW{1'b0}};
      chunk_cnt <= {KW{1'b0}};
      acc       <= {SUM_W{1'b0}};
      Frame_Out <= {FRAME{1'b0}};
      Out_Sum   <= {SUM_W{1'b0}};
      Out_Valid <= 1'b0;
      Frame_Cnt <= {CNT_W{1'b0}};
`ifdef DECOS_THRESH_EN
      Hit       <= 1'b0;
`endif
    end else if (Clear) begin
      // Frame_Out is left alone; the next frame overwrites it.
      state     <= FILL;
      beat_cnt  <= {BW{1'b0}};
      chunk_cnt <= {KW{1'b0}};
      acc       <= {SUM_W{1'b0}};
      Out_Valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (In_Valid) begin
            Frame_Out <= {In_Data, Frame_Out[FRAME-1:IN_W]};
            if (beat_cnt == BW'(BEATS - 1)) begin
              beat_cnt  <= {BW{1'b0}};
              chunk_cnt <= {KW{1'b0}};
              acc       <= {SUM_W{1'b0}};
              state     <= REDUCE;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        REDUCE: begin
          if (chunk_cnt == KW'(CHUNKS - 1)) begin
            Out_Sum   <= chunk_total;
            Out_Valid <= 1'b1;
            chunk_cnt <= {KW{1'b0}};
            state     <= HOLD;
`ifdef DECOS_THRESH_EN
            Hit       <= (chunk_total >= Threshold);
`endif
          end else begin
            acc       <= chunk_total;
            chunk_cnt <= chunk_cnt + KW'(1);
          end
        end
        HOLD: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            Frame_Cnt <= Frame_Cnt + 16'd1;
            beat_cnt  <= {BW{1'b0}};
            state     <= FILL;
          end
        end
        default: begin
          state     <= FILL;
          Out_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decos_suma_seq.sv
// Directed bench for decos_suma_seq: frame-level reference model plus literal expectations.
// Threshold/Hit checks are built when DECOS_THRESH_EN is defined.
module tb_decos_suma_seq;

  localparam int P_FILL = 0;
  localparam int P_RED  = 1;
  localparam int P_HOLD = 2;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Clear = 1'b0;
  logic [7:0]    In_Data = 8'h00;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [1023:0] Frame_Out;
  logic [10:0]   Out_Sum;
  logic          Out_Valid;
  logic          Out_Ready = 1'b0;
  logic [15:0]   Frame_Cnt;
  logic [10:0]   Threshold = 11'd600;
  logic          Hit;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_checks = 1'b0;

  decos_suma_seq dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Clear     (Clear),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Frame_Out (Frame_Out),
    .Out_Sum   (Out_Sum),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Frame_Cnt (Frame_Cnt)
`ifdef DECOS_THRESH_EN
    ,
    .Threshold (Threshold),
    .Hit       (Hit)
`endif
  );

`ifndef DECOS_THRESH_EN
  assign Hit = 1'b0;
`endif

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: beats collected into a byte array, ones counted per frame.
  logic [7:0]  m_bytes [128];
  int          m_phase, m_beats, m_red;
  int          m_pending;
  logic [10:0] m_sum;
  logic        m_valid, m_hit;
  logic [15:0] m_cnt;

  function automatic int frame_ones(input logic [7:0] last);
    int s = $countones(last);
    for (int i = 0; i < 127; i++) s += $countones(m_bytes[i]);
    return s;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_phase <= P_FILL; m_beats <= 0; m_red <= 0; m_pending <= 0;
      m_sum <= 11'd0; m_valid <= 1'b0; m_hit <= 1'b0; m_cnt <= 16'd0;
    end else if (Clear) begin
      m_phase <= P_FILL; m_beats <= 0; m_red <= 0; m_valid <= 1'b0;
    end else begin
      case (m_phase)
        P_FILL: if (In_Valid) begin
          m_bytes[m_beats] <= In_Data;
          if (m_beats == 127) begin
            m_phase <= P_RED; m_red <= 16; m_beats <= 0;
            m_pending <= frame_ones(In_Data);
          end else begin
            m_beats <= m_beats + 1;
          end
        end
        P_RED: begin
          m_red <= m_red - 1;
          if (m_red == 1) begin
            m_phase <= P_HOLD; m_valid <= 1'b1; m_sum <= 11'(m_pending);
            m_hit <= (m_pending >= int'(Threshold));
          end
        end
        P_HOLD: if (Out_Ready) begin
          m_phase <= P_FILL; m_valid <= 1'b0; m_cnt <= m_cnt + 16'd1;
        end
        default: m_phase <= P_FILL;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name);
    logic [1023:0] exp;
    int bad;
    for (int i = 0; i < 128; i++) exp[i*8 +: 8] = m_bytes[i];
    n_checks++;
    if (Frame_Out !== exp) begin
      n_fail++;
      bad = 0;
      for (int i = 127; i >= 0; i--) if (Frame_Out[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
      $display("FAIL %s: byte %0d got %02h, expected %02h at %0t",
               name, bad, Frame_Out[bad*8 +: 8], exp[bad*8 +: 8], $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge Clk) begin
    if (Rst_n && run_checks) begin
      check("in_ready", In_Ready, (m_phase == P_FILL));
      check("out_valid", Out_Valid, m_valid);
      check("out_sum", Out_Sum, m_sum);
      check("frame_cnt", Frame_Cnt, m_cnt);
      if (m_valid) begin
        check_frame("frame_out");
`ifdef DECOS_THRESH_EN
        check("hit", Hit, m_hit);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic send_beat(input logic [7:0] d);
    int n = 0;
    In_Data = d; In_Valid = 1'b1;
    while (!In_Ready && n < 200) begin tick(); n++; end
    if (!In_Ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_beat: In_Ready stuck low, got 0, expected 1");
    end
    tick();
    In_Valid = 1'b0;
  endtask

  // ramp: beat i carries i[7:0]; otherwise every beat carries fill.
  task automatic send_frame(input logic [7:0] fill, input bit ramp, input bit gaps);
    for (int i = 0; i < 128; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_beat(ramp ? 8'(i) : fill);
    end
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    while (!Out_Valid && n < 100) begin tick(); n++; end
    lat = n;
    if (!Out_Valid) begin
      n_checks++; n_fail++;
      $display("FAIL wait_valid: Out_Valid got 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic take_result(input int stall);
    Out_Ready = 1'b0;
    repeat (stall) tick();
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    run_checks = 1'b1;
    check("rst_out_valid", Out_Valid, 1'b0);
    check("rst_in_ready", In_Ready, 1'b1);
    check("rst_out_sum", Out_Sum, 11'd0);
    check("rst_frame_cnt", Frame_Cnt, 16'd0);
    check("rst_frame_out", Frame_Out[31:0], 32'h0);

    // 1: all ones, latency and count
    send_frame(8'hFF, 1'b0, 1'b0);
    wait_valid(lat);
    check("t1_latency", lat, 16);
    check("t1_sum", Out_Sum, 11'd1024);
    take_result(0);
    check("t1_cnt", Frame_Cnt, 16'd1);

    // 2: all zeros then alternating bits
    send_frame(8'h00, 1'b0, 1'b0);
    check("t2_ready_reduce", In_Ready, 1'b0);
    wait_valid(lat);
    check("t2_sum0", Out_Sum, 11'd0);
    check("t2_ready_hold", In_Ready, 1'b0);
    take_result(0);
    send_frame(8'hAA, 1'b0, 1'b0);
    wait_valid(lat);
    check("t2_sum_aa", Out_Sum, 11'd512);
`ifdef DECOS_THRESH_EN
    check("t6_hit_aa", Hit, 1'b0);
`endif
    take_result(0);
    check("t2_cnt", Frame_Cnt, 16'd3);

    // 3: ramp with random gaps
    send_frame(8'h00, 1'b1, 1'b1);
    wait_valid(lat);
    check("t3_latency", lat, 16);
    check("t3_sum", Out_Sum, 11'd448);
    check("t3_first_beat", Frame_Out[7:0], 8'h00);
    check("t3_last_beat", Frame_Out[1023:1016], 8'h7F);
    take_result(0);

    // 4: stalled result with beats offered
    send_frame(8'h03, 1'b0, 1'b0);
    wait_valid(lat);
    In_Data = 8'hEE; In_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", Out_Valid, 1'b1);
      check("t4_hold_sum", Out_Sum, 11'd256);
      check("t4_hold_ready", In_Ready, 1'b0);
      tick();
    end
    In_Valid = 1'b0;
    take_result(0);
    check("t4_cnt", Frame_Cnt, 16'd5);
    check("t4_valid_drop", Out_Valid, 1'b0);

    // 5: Clear during REDUCE cycle 5, then a clean frame
    send_frame(8'h0F, 1'b0, 1'b0);
    repeat (5) tick();
    Clear = 1'b1; tick(); Clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("t5_no_valid", Out_Valid, 1'b0);
      tick();
    end
    check("t5_cnt_kept", Frame_Cnt, 16'd5);
    send_frame(8'h0F, 1'b0, 1'b0);
    wait_valid(lat);
    check("t5_sum", Out_Sum, 11'd512);
    take_result(0);

    // 5b: Clear wins over a beat in FILL
    for (int i = 0; i < 3; i++) send_beat(8'h00);
    In_Data = 8'hFF; In_Valid = 1'b1; Clear = 1'b1;
    tick();
    Clear = 1'b0; In_Valid = 1'b0;
    send_frame(8'h01, 1'b0, 1'b0);
    wait_valid(lat);
    check("t5b_sum", Out_Sum, 11'd128);
    check("t5b_first", Frame_Out[7:0], 8'h01);
    check("t5b_last", Frame_Out[1023:1016], 8'h01);
    take_result(0);
    check("t5b_cnt", Frame_Cnt, 16'd7);

    // 6: all ones with threshold, then reset mid-FILL
    send_frame(8'hFF, 1'b0, 1'b0);
    wait_valid(lat);
    check("t6_sum", Out_Sum, 11'd1024);
`ifdef DECOS_THRESH_EN
    check("t6_hit_ones", Hit, 1'b1);
`endif
    take_result(0);
    for (int i = 0; i < 10; i++) send_beat(8'hFF);
    Rst_n = 1'b0;
    #2;
    check("t6_rst_valid", Out_Valid, 1'b0);
    check("t6_rst_cnt", Frame_Cnt, 16'd0);
    check("t6_rst_sum", Out_Sum, 11'd0);
    check("t6_rst_hit", Hit, 1'b0);
    tick();
    Rst_n = 1'b1;
    check("t6_rst_ready", In_Ready, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0);
    wait_valid(lat);
    check("t6_post_rst_sum", Out_Sum, 11'd128);
    take_result(2);
    check("t6_post_rst_cnt", Frame_Cnt, 16'd1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
